mobo_arbiter: RTL and testbench

Two-port motherboard access arbiter that sits between bus masters (port 0: cpu, port 1: debug/DMA master) and the single memory port. Each master drives the word-wide `mobo_ctrl`/`mobo_stat` handshake with its own address and data registers. The arbiter grants one request at a time, round-robin, and runs the read/write transaction on the memory port with a ready handshake and a timeout. It returns read data and a per-port DONE/ERR status.

---
 rtl/mobo_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mobo_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mobo_arbiter.sv
// Round-robin arbiter between two mobo_ctrl/mobo_stat masters and one memory port.
// Every output is registered; a memory access is aborted after TIMEOUT cycles without ready.
module mobo_arbiter #(
  parameter int word_width = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [word_width-1:0] ctrl0,
  input  logic [word_width-1:0] ctrl1,
  output logic [word_width-1:0] stat0,
  output logic [word_width-1:0] stat1,
  input  logic [word_width-1:0] addr0,
  input  logic [word_width-1:0] addr1,
  input  logic [word_width-1:0] wdata0,
  input  logic [word_width-1:0] wdata1,
  output logic [word_width-1:0] rdata0,
  output logic [word_width-1:0] rdata1,
  output logic [word_width-1:0] mem_addr,
  output logic [word_width-1:0] mem_wdata,
  output logic                  mem_re,
  output logic                  mem_we,
  input  logic [word_width-1:0] mem_rdata,
  input  logic                  mem_ready
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [word_width-1:0] C_READ  = word_width'(1);
  localparam logic [word_width-1:0] C_WRITE = word_width'(2);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  typedef enum logic [1:0] {A_IDLE, A_ACCESS, A_DONE} state_t;

  state_t                r_state, w_state;
  logic [1:0]            r_stat0, w_stat0;
  logic [1:0]            r_stat1, w_stat1;
  logic [word_width-1:0] r_rdata0, w_rdata0;
  logic [word_width-1:0] r_rdata1, w_rdata1;
  logic [word_width-1:0] r_addr, w_addr;
  logic [word_width-1:0] r_wdata, w_wdata;
  logic                  r_re, w_re;
  logic                  r_we, w_we;
  logic                  r_gnt, w_gnt;
  logic                  r_last, w_last;
  logic [CW-1:0]         r_cnt, w_cnt;

  logic w_op0, w_op1, w_req0, w_req1, w_pick, w_gnt_nop;

  assign w_op0  = (ctrl0 == C_READ) || (ctrl0 == C_WRITE);
  assign w_op1  = (ctrl1 == C_READ) || (ctrl1 == C_WRITE);
  assign w_req0 = w_op0 && (r_stat0 == S_IDLE);
  assign w_req1 = w_op1 && (r_stat1 == S_IDLE);
  // w_pick: 1 selects port 1; a tie goes to the port not granted last
  assign w_pick = !(w_req0 && (!w_req1 || r_last));
  assign w_gnt_nop = r_gnt ? !w_op1 : !w_op0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= A_IDLE;
      r_stat0  <= S_IDLE;
      r_stat1  <= S_IDLE;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_re     <= 1'b0;
      r_we     <= 1'b0;
      r_gnt    <= 1'b0;
      r_last   <= 1'b1;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state;
      r_stat0  <= w_stat0;
      r_stat1  <= w_stat1;
      r_rdata0 <= w_rdata0;
      r_rdata1 <= w_rdata1;
      r_addr   <= w_addr;
      r_wdata  <= w_wdata;
      r_re     <= w_re;
      r_we     <= w_we;
      r_gnt    <= w_gnt;
      r_last   <= w_last;
      r_cnt    <= w_cnt;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_stat0  = r_stat0;
    w_stat1  = r_stat1;
    w_rdata0 = r_rdata0;
    w_rdata1 = r_rdata1;
    w_addr   = r_addr;
    w_wdata  = r_wdata;
    w_re     = r_re;
    w_we     = r_we;
    w_gnt    = r_gnt;
    w_last   = r_last;
    w_cnt    = r_cnt;
    unique case (r_state)
      A_IDLE: begin
        if (w_req0 || w_req1) begin
          w_gnt   = w_pick;
          w_last  = w_pick;
          w_cnt   = '0;
          w_state = A_ACCESS;
          if (w_pick) begin
            w_addr  = addr1;
            w_wdata = wdata1;
            w_re    = (ctrl1 == C_READ);
            w_we    = (ctrl1 == C_WRITE);
            w_stat1 = S_BUSY;
          end else begin
            w_addr  = addr0;
            w_wdata = wdata0;
            w_re    = (ctrl0 == C_READ);
            w_we    = (ctrl0 == C_WRITE);
            w_stat0 = S_BUSY;
          end
        end
      end
      A_ACCESS: begin
        if (mem_ready) begin
          if (r_re && r_gnt)  w_rdata1 = mem_rdata;
          if (r_re && !r_gnt) w_rdata0 = mem_rdata;
          w_re    = 1'b0;
          w_we    = 1'b0;
          w_state = A_DONE;
          if (r_gnt) w_stat1 = S_DONE;
          else       w_stat0 = S_DONE;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_re    = 1'b0;
          w_we    = 1'b0;
          w_state = A_DONE;
          if (r_gnt) w_stat1 = S_ERR;
          else       w_stat0 = S_ERR;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      A_DONE: begin
        if (w_gnt_nop) begin
          w_state = A_IDLE;
          if (r_gnt) w_stat1 = S_IDLE;
          else       w_stat0 = S_IDLE;
        end
      end
      default: w_state = A_IDLE;
    endcase
  end

  assign stat0     = {{(word_width-2){1'b0}}, r_stat0};
  assign stat1     = {{(word_width-2){1'b0}}, r_stat1};
  assign rdata0    = r_rdata0;
  assign rdata1    = r_rdata1;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_re    = r_re;
  assign mem_we    = r_we;

endmodule

// File: tb/tb_mobo_arbiter.sv
// Directed bench for mobo_arbiter with a completion scoreboard.
module tb_mobo_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ctrl[2];
  logic [31:0] addr[2];
  logic [31:0] wdata[2];
  logic [31:0] stat[2];
  logic [31:0] rdata[2];
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_re, mem_we, mem_ready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          p;
    logic [31:0] st;
    logic [31:0] rd;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_rd[2];

  always #5 clk = ~clk;

  mobo_arbiter #(.word_width(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ctrl0(ctrl[0]), .ctrl1(ctrl[1]),
    .stat0(stat[0]), .stat1(stat[1]),
    .addr0(addr[0]), .addr1(addr[1]),
    .wdata0(wdata[0]), .wdata1(wdata[1]),
    .rdata0(rdata[0]), .rdata1(rdata[1]),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input int p);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty port=%0d observed=completion expected=none", p);
    end else begin
      e = sb.pop_front();
      chk("sb_port", p, e.p);
      chk("sb_stat", stat[p], e.st);
      chk("sb_rdata", rdata[p], e.rd);
    end
  endtask

  task automatic run_txn(input int p, input logic [31:0] op,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int ready_at, input logic [31:0] rd,
                         input bit glitch);
    int n;
    int o;
    logic [31:0] est;
    o = 1 - p;
    est = (ready_at != 0) ? 32'd2 : 32'd3;
    if (ready_at != 0 && op == 32'd1) exp_rd[p] = rd;
    sb.push_back('{p, est, exp_rd[p]});
    ctrl[p] = op;
    addr[p] = a;
    wdata[p] = wd;
    mem_rdata = rd;
    cyc();
    chk("busy", stat[p], 32'd1);
    chk("other_idle", stat[o], 32'd0);
    if (glitch) ctrl[p] = 32'd1;
    n = 0;
    while (stat[p] == 32'd1 && n < 40) begin
      n++;
      chk("re", {31'd0, mem_re}, {31'd0, op == 32'd1});
      chk("we", {31'd0, mem_we}, {31'd0, op == 32'd2});
      chk("addr", mem_addr, a);
      chk("wdata", mem_wdata, wd);
      mem_ready = (n == ready_at);
      cyc();
    end
    mem_ready = 1'b0;
    chk("strobe_cycles", n, (ready_at != 0) ? ready_at : TO);
    chk("strobes_low", {30'd0, mem_re, mem_we}, 32'd0);
    sb_pop(p);
    chk("other_rdata", rdata[o], exp_rd[o]);
    if (glitch) begin
      cyc();
      cyc();
      chk("done_hold", stat[p], est);
    end
    ctrl[p] = 32'd0;
    cyc();
    chk("idle", stat[p], 32'd0);
  endtask

  task automatic tie_round(input int w, input logic [31:0] rd);
    int l;
    l = 1 - w;
    exp_rd[w] = rd;
    sb.push_back('{w, 32'd2, rd});
    ctrl[0] = 32'd1;
    ctrl[1] = 32'd1;
    addr[0] = 32'h100;
    addr[1] = 32'h200;
    cyc();
    chk("tie_busy", stat[w], 32'd1);
    chk("tie_wait_idle", stat[l], 32'd0);
    chk("tie_addr", mem_addr, addr[w]);
    chk("tie_re", {31'd0, mem_re}, 32'd1);
    mem_ready = 1'b1;
    mem_rdata = rd;
    cyc();
    mem_ready = 1'b0;
    chk("tie_loser_idle", stat[l], 32'd0);
    sb_pop(w);
    chk("tie_loser_rdata", rdata[l], exp_rd[l]);
    ctrl[0] = 32'd0;
    ctrl[1] = 32'd0;
    cyc();
    chk("tie_idle0", stat[0], 32'd0);
    chk("tie_idle1", stat[1], 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    ctrl = '{32'd0, 32'd0};
    addr = '{32'd0, 32'd0};
    wdata = '{32'd0, 32'd0};
    exp_rd = '{32'd0, 32'd0};
    mem_rdata = 32'd0;
    mem_ready = 1'b0;
    cyc();
    cyc();
    chk("rst_stat0", stat[0], 32'd0);
    chk("rst_stat1", stat[1], 32'd0);
    chk("rst_rdata0", rdata[0], 32'd0);
    chk("rst_rdata1", rdata[1], 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_strobes", {30'd0, mem_re, mem_we}, 32'd0);
    rst = 1'b0;
    cyc();

    run_txn(0, 32'd2, 32'h10, 32'hDEADBEEF, 3, 32'h0, 1'b0);
    run_txn(1, 32'd1, 32'h20, 32'h0, 1, 32'h12345678, 1'b0);

    tie_round(0, 32'hA0A0_0001);
    tie_round(1, 32'hB1B1_0002);
    tie_round(0, 32'hC2C2_0003);

    run_txn(0, 32'd1, 32'h30, 32'h0, 0, 32'hFFFF_FFFF, 1'b0);
    run_txn(1, 32'd1, 32'h34, 32'h0, 2, 32'h5555_AAAA, 1'b0);

    run_txn(0, 32'd2, 32'h40, 32'hCAFE_F00D, 2, 32'h0, 1'b1);

    ctrl[0] = 32'd1;
    addr[0] = 32'h44;
    cyc();
    cyc();
    chk("pre_rst_re", {31'd0, mem_re}, 32'd1);
    rst = 1'b1;
    cyc();
    chk("mrst_strobes", {30'd0, mem_re, mem_we}, 32'd0);
    chk("mrst_stat0", stat[0], 32'd0);
    chk("mrst_stat1", stat[1], 32'd0);
    chk("mrst_rdata0", rdata[0], 32'd0);
    chk("mrst_rdata1", rdata[1], 32'd0);
    ctrl[0] = 32'd0;
    exp_rd = '{32'd0, 32'd0};
    rst = 1'b0;
    cyc();
    tie_round(0, 32'h7777_0004);
    tie_round(1, 32'h8888_0005);

    chk("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
